// File: rtl/apple1_pkg.sv
// apple1_pkg
// Shared definitions for the Apple-1 memory subsystem: default RAM
// geometry and the state encoding of the RAM arbiter.
package apple1_pkg;

    localparam int RAM_ADDR_W = 16;  // default RAM address width
    localparam int RAM_DATA_W = 8;   // default RAM data width

    // IDLE    : CPU owns the RAM, DMA grant decided here
    // DMA_ACC : latched DMA address/data drive the RAM for one cycle
    // DMA_CAP : RAM read data of the DMA access is valid on ram_dout
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DMA_ACC = 2'd1,
        DMA_CAP = 2'd2
    } arb_state_t;

endpackage : apple1_pkg

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one synchronous RAM between the CPU and a DMA loader. The CPU
// always wins: a DMA access is only started when neither the current nor
// the next cycle is a CPU slot, so the single DMA_ACC cycle can never
// coincide with cpu_clken. The CPU path is purely combinational.
//
// A DMA transfer takes three cycles (IDLE grant, DMA_ACC, DMA_CAP). The
// completion outputs are registered: at the end of DMA_CAP the read byte
// is captured from ram_dout, the counter steps and dma_ack is raised, so
// dma_ack, dma_rdata and dma_count change together and dma_ack lasts
// exactly one cycle.
//
// Ports
//   sys_clock, reset_n            : clock (rising edge), async active-low reset
//   cpu_clken, cpu_slot_pre       : CPU slot strobe and its one-cycle lookahead
//   cpu_addr/wdata/we/ram_cs      : CPU RAM request
//   cpu_rdata                     : RAM read data to CPU (= ram_dout)
//   dma_req/we/addr/wdata         : DMA loader request
//   dma_ack, dma_rdata, dma_count : completion pulse, read byte, transfer count
//   ram_addr/din/rd/wr, ram_dout  : synchronous RAM port
module ram_arbiter
    import apple1_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic              sys_clock,
    input  logic              reset_n,
    input  logic              cpu_clken,
    input  logic              cpu_slot_pre,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_ram_cs,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [15:0]       dma_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_t        state;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // Grant only when this cycle is not a CPU slot and the next one is not
    // either; the access cycle then falls between two CPU slots.
    logic grant;
    assign grant = dma_req & ~cpu_slot_pre & ~cpu_clken;

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            dma_ack   <= 1'b0;
            dma_rdata <= '0;
            dma_count <= '0;
        end else begin
            dma_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= DMA_ACC;
                        lat_we    <= dma_we;
                        lat_addr  <= dma_addr;
                        lat_wdata <= dma_wdata;
                    end
                end
                DMA_ACC: begin
                    state <= DMA_CAP;
                end
                DMA_CAP: begin
                    // Writes leave the previously captured read byte in place.
                    if (!lat_we) begin
                        dma_rdata <= ram_dout;
                    end
                    dma_ack   <= 1'b1;
                    dma_count <= dma_count + 16'd1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // RAM port mux. Decoded from the state register only, so a reset in the
    // middle of a transfer hands the RAM back to the CPU immediately.
    // NOTE: every output is given a value on every path of this block, which
    // keeps it purely combinational (no latches).
    always_comb begin
        if (state == DMA_ACC) begin
            ram_addr = lat_addr;
            ram_din  = lat_wdata;
            ram_rd   = ~lat_we;
            ram_wr   = lat_we;
        end else begin
            ram_addr = cpu_addr;
            ram_din  = cpu_wdata;
            ram_rd   = cpu_ram_cs;
            ram_wr   = cpu_we & cpu_ram_cs & cpu_clken;
        end
    end

    assign cpu_rdata = ram_dout;

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter: a table of CPU-path vectors followed by
// hand-written DMA sequences. The bench owns a synchronous RAM model and a
// CPU slot generator (every 4th cycle, or manual control).
module tb_ram_arbiter;

    localparam int AW = 16;
    localparam int DW = 8;

    logic          sys_clock;
    logic          reset_n;
    logic          cpu_clken;
    logic          cpu_slot_pre;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic          cpu_ram_cs;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic [15:0]   dma_count;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rd;
    logic          ram_wr;
    logic [DW-1:0] ram_dout;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sys_clock    (sys_clock),
        .reset_n      (reset_n),
        .cpu_clken    (cpu_clken),
        .cpu_slot_pre (cpu_slot_pre),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_we       (cpu_we),
        .cpu_ram_cs   (cpu_ram_cs),
        .cpu_rdata    (cpu_rdata),
        .dma_req      (dma_req),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_wdata    (dma_wdata),
        .dma_ack      (dma_ack),
        .dma_rdata    (dma_rdata),
        .dma_count    (dma_count),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_rd       (ram_rd),
        .ram_wr       (ram_wr),
        .ram_dout     (ram_dout)
    );

    initial sys_clock = 1'b0;
    always #5 sys_clock = ~sys_clock;

    // Synchronous RAM model: data valid one cycle after the address.
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] ram_q;
    logic          dout_ovr_en;
    logic [DW-1:0] dout_ovr;

    always @(posedge sys_clock) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        ram_q <= mem[ram_addr];
    end
    assign ram_dout = dout_ovr_en ? dout_ovr : ram_q;

    // Bookkeeping
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: ack counting, adjacent-ack and CPU-slot ownership checks.
    int   ack_total = 0;
    int   adj_err   = 0;
    int   slot_err  = 0;
    logic ack_prev  = 1'b0;
    logic mon_en    = 1'b0;

    always @(negedge sys_clock) begin
        if (dma_ack && ack_prev) adj_err++;
        if (dma_ack) ack_total++;
        ack_prev = dma_ack;
        if (mon_en && cpu_clken && (ram_addr !== cpu_addr || ram_rd !== cpu_ram_cs))
            slot_err++;
    end

    // CPU slot generator: mode 0 manual, mode 1 every 4th cycle, mode 2 every cycle.
    int cpu_mode = 0;
    int phase    = 0;

    task automatic tick();
        @(posedge sys_clock);
        #1;
        if (cpu_mode == 1) begin
            phase        = (phase + 1) % 4;
            cpu_slot_pre = (phase == 2);
            cpu_clken    = (phase == 3);
        end else if (cpu_mode == 2) begin
            cpu_slot_pre = 1'b1;
            cpu_clken    = 1'b1;
        end
        #1;
    endtask

    task automatic wait_phase(input int p);
        for (int k = 0; k < 8 && phase != p; k++) tick();
        check("phase_sync", 32'(phase), 32'(p));
    endtask

    task automatic cpu_idle();
        cpu_addr   = 16'h0040;
        cpu_wdata  = 8'h00;
        cpu_we     = 1'b0;
        cpu_ram_cs = 1'b0;
    endtask

    // Manual-mode CPU write used to preload RAM contents.
    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_ram_cs = 1'b1; cpu_clken = 1'b1;
        tick();
        cpu_idle();
        cpu_clken = 1'b0;
    endtask

    typedef struct {
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic          c_we;
        logic          c_cs;
        logic          c_clken;
        logic [DW-1:0] dout;
        logic          e_rd;
        logic          e_wr;
    } vec_t;

    vec_t vecs [7];

    int a0, adj0, slot0, i;

    initial begin
        // Test table: CPU path while the arbiter is idle.
        vecs[0] = '{16'h5000, 8'h11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[1] = '{16'h5001, 8'h22, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
        vecs[2] = '{16'h5002, 8'h33, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{16'h5003, 8'h44, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
        vecs[4] = '{16'h5004, 8'h55, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1};

        reset_n = 1'b0;
        cpu_clken = 1'b0; cpu_slot_pre = 1'b0;
        cpu_idle();
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        dout_ovr_en = 1'b0; dout_ovr = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_ack",   32'(dma_ack),   32'h0);
        check("rst_rdata", 32'(dma_rdata), 32'h0);
        check("rst_count", 32'(dma_count), 32'h0);
        reset_n = 1'b1;
        tick();

        // Combinational CPU path vectors
        dout_ovr_en = 1'b1;
        for (int v = 0; v < 7; v++) begin
            cpu_addr = vecs[v].c_addr; cpu_wdata = vecs[v].c_wdata;
            cpu_we = vecs[v].c_we; cpu_ram_cs = vecs[v].c_cs; cpu_clken = vecs[v].c_clken;
            dout_ovr = vecs[v].dout;
            #1;
            check($sformatf("vec%0d_addr", v),  32'(ram_addr),  32'(vecs[v].c_addr));
            check($sformatf("vec%0d_din", v),   32'(ram_din),   32'(vecs[v].c_wdata));
            check($sformatf("vec%0d_rd", v),    32'(ram_rd),    32'(vecs[v].e_rd));
            check($sformatf("vec%0d_wr", v),    32'(ram_wr),    32'(vecs[v].e_wr));
            check($sformatf("vec%0d_rdata", v), 32'(cpu_rdata), 32'(vecs[v].dout));
            tick();
        end
        dout_ovr_en = 1'b0;
        cpu_idle();
        cpu_clken = 1'b0;
        cpu_write(16'h0300, 8'hA9);
        cpu_write(16'h3000, 8'h11);
        tick();

        // DMA read of 0x0300 in the idle gap between CPU slots
        cpu_mode = 1; phase = 3; mon_en = 1'b1;
        tick();
        wait_phase(0);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
        tick();                                   // DMA_ACC
        check("rd_acc_addr", 32'(ram_addr), 32'h0300);
        check("rd_acc_rd",   32'(ram_rd),   32'h1);
        check("rd_acc_wr",   32'(ram_wr),   32'h0);
        dma_req = 1'b0; dma_addr = 16'h0BAD;
        tick();                                   // DMA_CAP
        tick();
        check("rd_ack",   32'(dma_ack),   32'h1);
        check("rd_rdata", 32'(dma_rdata), 32'hA9);
        check("rd_count", 32'(dma_count), 32'h1);

        // Request raised in a cpu_slot_pre cycle, CPU writes 0x55 to 0x0010
        wait_phase(2);
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h2000; dma_wdata = 8'h77;
        cpu_addr = 16'h0010; cpu_wdata = 8'h55; cpu_we = 1'b1; cpu_ram_cs = 1'b1;
        #1;
        check("pre_no_grant_addr", 32'(ram_addr), 32'h0010);
        tick();                                   // CPU slot
        check("slot_cpu_addr", 32'(ram_addr), 32'h0010);
        check("slot_cpu_din",  32'(ram_din),  32'h55);
        check("slot_cpu_wr",   32'(ram_wr),   32'h1);
        tick();                                   // grant decided here
        check("post_slot_no_acc", 32'(ram_addr), 32'h0010);
        cpu_idle();
        tick();                                   // DMA_ACC
        check("wr_acc_addr", 32'(ram_addr), 32'h2000);
        check("wr_acc_din",  32'(ram_din),  32'h77);
        check("wr_acc_wr",   32'(ram_wr),   32'h1);
        dma_req = 1'b0;
        tick(); tick();
        check("wr_ack",   32'(dma_ack),   32'h1);
        check("wr_count", 32'(dma_count), 32'h2);
        check("wr_rdata_held", 32'(dma_rdata), 32'hA9);
        tick();
        check("cpu_write_mem", 32'(mem[16'h0010]), 32'h55);
        check("dma_write_mem", 32'(mem[16'h2000]), 32'h77);

        // Back-to-back DMA writes 0x00..0x0F to 0x1000.. with dma_req held
        a0 = ack_total; adj0 = adj_err; slot0 = slot_err;
        i = 0;
        dma_we = 1'b1; dma_addr = 16'h1000; dma_wdata = 8'h00; dma_req = 1'b1;
        for (int c = 0; c < 200 && i < 16; c++) begin
            tick();
            if (dma_ack) begin
                i++;
                if (i < 16) begin
                    dma_addr  = 16'h1000 + 16'(i);
                    dma_wdata = 8'(i);
                end else begin
                    dma_req = 1'b0;
                end
            end
        end
        tick();
        check("burst_done",      32'(i),                 32'd16);
        check("burst_acks",      32'(ack_total - a0),    32'd16);
        check("burst_adjacent",  32'(adj_err - adj0),    32'd0);
        check("burst_cpu_slots", 32'(slot_err - slot0),  32'd0);
        check("burst_count",     32'(dma_count),         32'd18);
        for (int j = 0; j < 16; j++)
            check($sformatf("burst_mem%0d", j), 32'(mem[16'h1000 + 16'(j)]), 32'(j));
        mon_en = 1'b0;

        // Request dropped during DMA_ACC still completes once
        cpu_mode = 0; cpu_clken = 1'b0; cpu_slot_pre = 1'b0;
        tick();
        a0 = ack_total;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
        tick();                                   // DMA_ACC
        dma_req = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        check("drop_acks",  32'(ack_total - a0), 32'd1);
        check("drop_count", 32'(dma_count),      32'd19);
        check("drop_rdata", 32'(dma_rdata),      32'hA9);

        // Reset asserted during DMA_ACC
        a0 = ack_total;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h3000; dma_wdata = 8'h99;
        tick();                                   // DMA_ACC
        check("rst_acc_wr", 32'(ram_wr), 32'h1);
        cpu_addr = 16'h0077; cpu_we = 1'b1; cpu_ram_cs = 1'b1; cpu_clken = 1'b0;
        reset_n = 1'b0;
        dma_req = 1'b0;
        #1;
        check("rst_mid_addr",  32'(ram_addr),  32'h0077);
        check("rst_mid_wr",    32'(ram_wr),    32'h0);
        check("rst_mid_count", 32'(dma_count), 32'h0);
        check("rst_mid_rdata", 32'(dma_rdata), 32'h0);
        tick(); tick();
        reset_n = 1'b1;
        cpu_idle();
        for (int c = 0; c < 4; c++) tick();
        check("rst_no_ack",   32'(ack_total - a0), 32'd0);
        check("rst_count",    32'(dma_count),      32'd0);
        check("rst_mem_kept", 32'(mem[16'h3000]),  32'h11);
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h3000;
        tick();
        check("rst_regrant_rd", 32'(ram_rd), 32'h1);
        dma_req = 1'b0;
        tick(); tick();
        check("rst_after_ack",   32'(dma_ack),   32'h1);
        check("rst_after_rdata", 32'(dma_rdata), 32'h11);
        check("rst_after_count", 32'(dma_count), 32'h1);

        // CPU slot every cycle starves DMA
        cpu_mode = 2;
        tick();
        a0 = ack_total;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4000; dma_wdata = 8'hEE;
        for (int c = 0; c < 20; c++) tick();
        check("starve_acks",  32'(ack_total - a0), 32'd0);
        check("starve_count", 32'(dma_count),      32'd1);
        dma_req = 1'b0;
        cpu_mode = 0; cpu_clken = 1'b0; cpu_slot_pre = 1'b0;
        tick();

        // Counter wrap: preset to 0xFFFF, then one more transfer
        force dut.dma_count = 16'hFFFF;
        tick();
        release dut.dma_count;
        tick();
        check("wrap_preset", 32'(dma_count), 32'hFFFF);
        a0 = ack_total;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0300;
        tick();
        dma_req = 1'b0;
        tick(); tick();
        check("wrap_ack",   32'(dma_ack),   32'h1);
        check("wrap_count", 32'(dma_count), 32'h0);
        tick();
        check("wrap_acks",  32'(ack_total - a0), 32'd1);
        check("adjacent_total", 32'(adj_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ram_arbiter
